// File: rtl/mem_stage.sv
// mem_stage: data-memory pipeline stage with wait-state FSM and MEM/WB register.
// Ports: clk, CLR_n (async rst), CLR (flush), EX/MEM *_in fields, Stall, MEM/WB outputs.
// Optional: define MEM_STAGE_MISALIGN_TRAP_EN to detect misaligned half/word ops.
module mem_stage #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        CLR_n,
  input  logic        CLR,
  input  logic        In,
  input  logic [31:0] IR_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] R1_in,
  input  logic [31:0] R2_in,
  input  logic [31:0] RD2_in,
  input  logic [4:0]  WbRegNum_in,
  input  logic        RegWrite_in,
  input  logic        LOWrite_in,
  input  logic        HIWrite_in,
  input  logic        MemtoReg_in,
  input  logic        MemWrite_in,
  input  logic        UnsignedExt_Mem_in,
  input  logic        Byte_in,
  input  logic        Half_in,
  output logic        Stall,
  output logic        Out,
  output logic [31:0] IR,
  output logic [31:0] PC,
  output logic [31:0] R1,
  output logic [31:0] R2,
  output logic [31:0] MemData,
  output logic [4:0]  WbRegNum,
  output logic        RegWrite,
  output logic        LOWrite,
  output logic        HIWrite,
  output logic        MemtoReg,
  output logic        MisAlign
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        mem_op;
  logic        is_byte, is_half, is_word;
  logic        misalign;
  logic        acc;
  logic        do_wr;
  logic        is_load;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wdat;
  logic [31:0] rword;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] ld_data;

  logic [31:0] ram [DEPTH];

  logic unused;
  assign unused = ^R1_in[31:DEPTH_LOG2+2];

  assign mem_op  = In & (MemWrite_in | MemtoReg_in);
  assign is_byte = Byte_in;
  assign is_half = ~Byte_in & Half_in;
  assign is_word = ~Byte_in & ~Half_in;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misalign = mem_op &
    ((is_half & R1_in[0]) | (is_word & (R1_in[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign acc = mem_op & ~misalign;
  assign idx = R1_in[DEPTH_LOG2+1:2];

  // Last WAIT cycle (cnt==0) is the completion cycle, so no stall there.
  assign Stall = HAS_WAIT & acc & ~CLR &
                 ~(state_q == WAIT && cnt_q == 4'd0);

  assign do_wr   = CLR_n & ~CLR & ~Stall & acc & MemWrite_in;
  assign is_load = acc & MemtoReg_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (CLR) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc && HAS_WAIT) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    be   = 4'b0000;
    wdat = RD2_in;
    unique case (1'b1)
      is_byte: begin
        be[R1_in[1:0]] = 1'b1;
        wdat = {4{RD2_in[7:0]}};
      end
      is_half: begin
        be   = R1_in[1] ? 4'b1100 : 4'b0011;
        wdat = {2{RD2_in[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (do_wr && be[i]) begin
        ram[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  assign rword = ram[idx];
  assign rbyte = rword[8*R1_in[1:0] +: 8];
  assign rhalf = R1_in[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ld_data = rword;
    unique case (1'b1)
      is_byte: ld_data = UnsignedExt_Mem_in ? {24'd0, rbyte}
                                            : {{24{rbyte[7]}}, rbyte};
      is_half: ld_data = UnsignedExt_Mem_in ? {16'd0, rhalf}
                                            : {{16{rhalf[15]}}, rhalf};
      default: ld_data = rword;
    endcase
  end

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      Out      <= 1'b0;
      IR       <= 32'd0;
      PC       <= 32'd0;
      R1       <= 32'd0;
      R2       <= 32'd0;
      MemData  <= 32'd0;
      WbRegNum <= 5'd0;
      RegWrite <= 1'b0;
      LOWrite  <= 1'b0;
      HIWrite  <= 1'b0;
      MemtoReg <= 1'b0;
      MisAlign <= 1'b0;
    end else if (CLR) begin
      Out      <= 1'b0;
      RegWrite <= 1'b0;
      LOWrite  <= 1'b0;
      HIWrite  <= 1'b0;
      MemtoReg <= 1'b0;
      MisAlign <= 1'b0;
    end else if (Stall) begin
      Out      <= 1'b0;
      RegWrite <= 1'b0;
      LOWrite  <= 1'b0;
      HIWrite  <= 1'b0;
      MemtoReg <= 1'b0;
    end else begin
      Out      <= In;
      IR       <= IR_in;
      PC       <= PC_in;
      R1       <= R1_in;
      R2       <= R2_in;
      MemData  <= is_load ? ld_data : 32'd0;
      WbRegNum <= WbRegNum_in;
      RegWrite <= RegWrite_in & ~misalign;
      LOWrite  <= LOWrite_in;
      HIWrite  <= HIWrite_in;
      MemtoReg <= MemtoReg_in & ~misalign;
      MisAlign <= misalign;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Drives ops after posedge, samples on negedge or #1 after posedge.
module tb_mem_stage;

  logic        clk;
  logic        CLR_n;
  logic        CLR;
  logic        In;
  logic [31:0] IR_in, PC_in, R1_in, R2_in, RD2_in;
  logic [4:0]  WbRegNum_in;
  logic        RegWrite_in, LOWrite_in, HIWrite_in;
  logic        MemtoReg_in, MemWrite_in, UnsignedExt_Mem_in;
  logic        Byte_in, Half_in;
  logic        Stall, Out;
  logic [31:0] IR, PC, R1, R2, MemData;
  logic [4:0]  WbRegNum;
  logic        RegWrite, LOWrite, HIWrite, MemtoReg, MisAlign;

  int total = 0;
  int bad   = 0;

  mem_stage #(
    .DEPTH_LOG2(8),
    .WAIT_CYCLES(2)
  ) dut (
    .clk(clk),
    .CLR_n(CLR_n),
    .CLR(CLR),
    .In(In),
    .IR_in(IR_in),
    .PC_in(PC_in),
    .R1_in(R1_in),
    .R2_in(R2_in),
    .RD2_in(RD2_in),
    .WbRegNum_in(WbRegNum_in),
    .RegWrite_in(RegWrite_in),
    .LOWrite_in(LOWrite_in),
    .HIWrite_in(HIWrite_in),
    .MemtoReg_in(MemtoReg_in),
    .MemWrite_in(MemWrite_in),
    .UnsignedExt_Mem_in(UnsignedExt_Mem_in),
    .Byte_in(Byte_in),
    .Half_in(Half_in),
    .Stall(Stall),
    .Out(Out),
    .IR(IR),
    .PC(PC),
    .R1(R1),
    .R2(R2),
    .MemData(MemData),
    .WbRegNum(WbRegNum),
    .RegWrite(RegWrite),
    .LOWrite(LOWrite),
    .HIWrite(HIWrite),
    .MemtoReg(MemtoReg),
    .MisAlign(MisAlign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    In = 1'b0;
    IR_in = 32'd0;
    PC_in = 32'd0;
    R1_in = 32'd0;
    R2_in = 32'd0;
    RD2_in = 32'd0;
    WbRegNum_in = 5'd0;
    RegWrite_in = 1'b0;
    LOWrite_in = 1'b0;
    HIWrite_in = 1'b0;
    MemtoReg_in = 1'b0;
    MemWrite_in = 1'b0;
    UnsignedExt_Mem_in = 1'b0;
    Byte_in = 1'b0;
    Half_in = 1'b0;
  endtask

  // we/re: store/load; b/h: size; u: unsigned load
  task automatic set_op(input logic we, input logic re,
                        input logic b, input logic h,
                        input logic u, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] ir);
    In = 1'b1;
    IR_in = ir;
    PC_in = 32'h0000_4000 + a;
    R1_in = a;
    R2_in = 32'h0;
    RD2_in = d;
    WbRegNum_in = 5'd7;
    RegWrite_in = re;
    LOWrite_in = 1'b0;
    HIWrite_in = 1'b0;
    MemtoReg_in = re;
    MemWrite_in = we;
    UnsignedExt_Mem_in = u;
    Byte_in = b;
    Half_in = h;
  endtask

  // Runs the op currently on the inputs to completion, checks stall count.
  task automatic run_op(input string tag, input int exp_stalls);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (n > 0) chk({tag, "_bubble"}, 32'(Out), 32'd0);
      if (!Stall) break;
      n++;
      if (n > 40) begin
        chk({tag, "_timeout"}, 32'(n), 32'(exp_stalls));
        break;
      end
    end
    @(posedge clk);
    #1;
    idle_in();
    chk({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
  endtask

  initial begin
    CLR_n = 1'b0;
    CLR = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(Out), 32'd0);
    chk("rst_memdata", MemData, 32'd0);
    chk("rst_ir", IR, 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    CLR_n = 1'b1;
    @(posedge clk);
    #1;

    set_op(1, 0, 0, 0, 0, 32'h10, 32'hDEADBEEF, 32'hAAAA0001);
    run_op("st_word", 2);
    chk("st_word_out", 32'(Out), 32'd1);
    chk("st_word_ir", IR, 32'hAAAA0001);
    chk("st_word_md", MemData, 32'd0);

    set_op(0, 1, 0, 0, 0, 32'h10, 32'h0, 32'hAAAA0002);
    run_op("ld_word", 2);
    chk("ld_word_md", MemData, 32'hDEADBEEF);
    chk("ld_word_out", 32'(Out), 32'd1);
    chk("ld_word_rw", 32'(RegWrite), 32'd1);
    chk("ld_word_wb", 32'(WbRegNum), 32'd7);
    chk("ld_word_pc", PC, 32'h0000_4010);

    set_op(1, 0, 0, 0, 0, 32'h10, 32'h80FF7F01, 32'h1);
    run_op("st_w2", 2);
    set_op(0, 1, 1, 0, 0, 32'h13, 32'h0, 32'h2);
    run_op("ldb_s13", 2);
    chk("ldb_s13_md", MemData, 32'hFFFFFF80);
    set_op(0, 1, 1, 0, 1, 32'h13, 32'h0, 32'h3);
    run_op("ldb_u13", 2);
    chk("ldb_u13_md", MemData, 32'h00000080);
    set_op(0, 1, 1, 0, 0, 32'h11, 32'h0, 32'h4);
    run_op("ldb_s11", 2);
    chk("ldb_s11_md", MemData, 32'h0000007F);
    set_op(0, 1, 1, 0, 0, 32'h12, 32'h0, 32'h5);
    run_op("ldb_s12", 2);
    chk("ldb_s12_md", MemData, 32'hFFFFFFFF);
    set_op(0, 1, 1, 1, 1, 32'h12, 32'h0, 32'h6);
    run_op("ldb_bh12", 2);
    chk("ldb_bh12_md", MemData, 32'h000000FF);

    set_op(1, 0, 0, 0, 0, 32'h10, 32'h11223344, 32'h7);
    run_op("st_w3", 2);
    set_op(1, 0, 0, 1, 0, 32'h12, 32'h0000ABCD, 32'h8);
    run_op("st_h12", 2);
    set_op(0, 1, 0, 0, 0, 32'h10, 32'h0, 32'h9);
    run_op("ld_w3", 2);
    chk("ld_w3_md", MemData, 32'hABCD3344);
    set_op(0, 1, 0, 1, 0, 32'h12, 32'h0, 32'hA);
    run_op("ldh_s12", 2);
    chk("ldh_s12_md", MemData, 32'hFFFFABCD);
    set_op(0, 1, 0, 1, 1, 32'h10, 32'h0, 32'hB);
    run_op("ldh_u10", 2);
    chk("ldh_u10_md", MemData, 32'h00003344);

    set_op(1, 0, 1, 0, 0, 32'h21, 32'h000000C3, 32'hC);
    run_op("st_b21", 2);
    set_op(0, 1, 0, 0, 1, 32'h20, 32'h0, 32'hD);
    run_op("ld_w20", 2);
    chk("ld_w20_b1", 32'(MemData[15:8]), 32'h000000C3);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    set_op(0, 1, 0, 1, 0, 32'h11, 32'h0, 32'hE);
    run_op("ldh_mis", 0);
    chk("ldh_mis_flag", 32'(MisAlign), 32'd1);
    chk("ldh_mis_rw", 32'(RegWrite), 32'd0);
    chk("ldh_mis_m2r", 32'(MemtoReg), 32'd0);
    chk("ldh_mis_out", 32'(Out), 32'd1);
    set_op(1, 0, 0, 0, 0, 32'h12, 32'h99999999, 32'hE1);
    run_op("stw_mis", 0);
    chk("stw_mis_flag", 32'(MisAlign), 32'd1);
`else
    set_op(0, 1, 0, 1, 0, 32'h11, 32'h0, 32'hE);
    run_op("ldh_mis", 2);
    chk("ldh_mis_md", MemData, 32'h00003344);
    chk("ldh_mis_flag", 32'(MisAlign), 32'd0);
    chk("ldh_mis_rw", 32'(RegWrite), 32'd1);
`endif
    set_op(0, 1, 0, 0, 0, 32'h10, 32'h0, 32'hE2);
    run_op("ld_chk_mis", 2);
    chk("ld_chk_mis_md", MemData, 32'hABCD3344);
    chk("ld_chk_mis_flag", 32'(MisAlign), 32'd0);

    set_op(0, 0, 0, 0, 0, 32'h55, 32'h0, 32'h12345678);
    R2_in = 32'hCAFE0000;
    HIWrite_in = 1'b1;
    RegWrite_in = 1'b1;
    run_op("alu", 0);
    chk("alu_ir", IR, 32'h12345678);
    chk("alu_r1", R1, 32'h55);
    chk("alu_r2", R2, 32'hCAFE0000);
    chk("alu_hi", 32'(HIWrite), 32'd1);
    chk("alu_rw", 32'(RegWrite), 32'd1);
    chk("alu_md", MemData, 32'd0);

    set_op(1, 0, 0, 0, 0, 32'h10, 32'h55555555, 32'hF);
    @(negedge clk);
    chk("clr_pre_stall", 32'(Stall), 32'd1);
    @(posedge clk);
    #1;
    CLR = 1'b1;
    @(negedge clk);
    chk("clr_stall", 32'(Stall), 32'd0);
    @(posedge clk);
    #1;
    CLR = 1'b0;
    idle_in();
    @(negedge clk);
    chk("clr_out", 32'(Out), 32'd0);
    chk("clr_stall2", 32'(Stall), 32'd0);
    chk("clr_mis", 32'(MisAlign), 32'd0);
    @(posedge clk);
    #1;
    set_op(0, 1, 0, 0, 0, 32'h10, 32'h0, 32'h10);
    run_op("clr_ld", 2);
    chk("clr_ld_md", MemData, 32'hABCD3344);

    set_op(1, 0, 0, 0, 0, 32'h10, 32'h66666666, 32'h11);
    @(negedge clk);
    @(posedge clk);
    #1;
    CLR_n = 1'b0;
    #1;
    chk("arst_out", 32'(Out), 32'd0);
    chk("arst_md", MemData, 32'd0);
    chk("arst_ir", IR, 32'd0);
    chk("arst_rw", 32'(RegWrite), 32'd0);
    @(posedge clk);
    #1;
    idle_in();
    CLR_n = 1'b1;
    @(posedge clk);
    #1;
    set_op(0, 1, 0, 0, 0, 32'h10, 32'h0, 32'h12);
    run_op("arst_ld", 2);
    chk("arst_ld_md", MemData, 32'hABCD3344);
    set_op(1, 0, 0, 0, 0, 32'h20, 32'h0BADF00D, 32'h13);
    run_op("arst_st2", 2);
    set_op(0, 1, 0, 0, 0, 32'h20, 32'h0, 32'h14);
    run_op("arst_ld2", 2);
    chk("arst_ld2_md", MemData, 32'h0BADF00D);
    chk("arst_ld2_out", 32'(Out), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
